// File: rtl/stream_mux_n_if.sv
// Stream bundle around stream_mux_n: N input channels, one output channel,
// plus the selection controls. The mux uses the slave view, the environment
// the master view.
interface stream_mux_n_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
);
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SEL_W-1:0]   sel;
    logic               rr_en;
    logic [WIDTH-1:0]   out_data;
    logic [SEL_W-1:0]   out_ch;
    logic               out_valid;
    logic               out_ready;

    // Producers and consumer side
    modport master (
        output in_data, in_valid, sel, rr_en, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    // Multiplexer side
    modport slave (
        input  in_data, in_valid, sel, rr_en, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with one registered output stage.
// Source is chosen either by an explicit select or by round-robin arbitration
// starting after the last served channel.
module stream_mux_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 4
) (
    input logic          clk,
    input logic          rst,
    stream_mux_n_if.slave bus
);
    localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NP    = 1 << SEL_W;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic             grant_ok;
    logic [SEL_W-1:0] grant;
    logic [NP-1:0]    valid_pad;
    logic [WIDTH-1:0] words [N];

    // Padding bits are zero, so an out-of-range select sees no valid channel
    assign valid_pad = NP'(bus.in_valid);
    assign load_en   = ~out_valid_q | bus.out_ready;

    // Unpack the flat input bus into per-channel words
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            words[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    // Grant selection: explicit select, or first valid channel after ptr
    always_comb begin
        int               idx;
        logic [SEL_W-1:0] idx_w;
        grant    = '0;
        grant_ok = 1'b0;
        idx      = 0;
        idx_w    = '0;
        if (!bus.rr_en) begin
            grant    = bus.sel;
            grant_ok = valid_pad[bus.sel];
        end else begin
            // Scan from farthest to nearest so the nearest valid channel wins
            for (int k = int'(N); k > 0; k--) begin
                idx   = (int'(ptr_q) + k) % int'(N);
                idx_w = SEL_W'(idx);
                if (valid_pad[idx_w]) begin
                    grant    = idx_w;
                    grant_ok = 1'b1;
                end
            end
        end
    end

    // One-hot ready toward the granted channel, suppressed during reset
    always_comb begin
        bus.in_ready = '0;
        if (!rst && load_en && grant_ok) begin
            bus.in_ready[grant] = 1'b1;
        end
    end

    // Next-state of the output register and arbitration pointer
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (load_en) begin
            if (grant_ok) begin
                out_data_d  = words[grant];
                out_ch_d    = grant;
                out_valid_d = 1'b1;
                ptr_d       = grant;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // State registers; ptr resets to N-1 so channel 0 is served first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= SEL_W'(N - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshaking on every input and on the output, and a single registered output stage. It succeeds the combinational 2-to-1 `mux_2to1` in the datapath library. Two selection modes are available:
- **Explicit-select mode:** an external `sel` port chooses the source channel.
- **Round-robin mode:** the block arbitrates fairly among the channels that are valid.

It sits between several producers and one consumer, and sustains one word per cycle.

## Interface
Parameters:
- `WIDTH`, 8: data width per channel in bits.
- `N`, 4: number of input channels, 2..16. It need not be a power of two.
- `SEL_W`, local, not overridable: ceil(log2(N)), minimum 1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N  per-channel valid.
- `in_ready`  out  N  per-channel ready, combinational.
- `sel`  in  SEL_W  source channel in explicit mode; ignored in round-robin mode.
- `rr_en`  in  1  0 = explicit-select mode, 1 = round-robin mode; sampled combinationally every cycle.
- `out_data`  out  WIDTH  registered output word.
- `out_ch`  out  SEL_W  channel index that `out_data` came from.
- `out_valid`  out  1  output register holds a word.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- **Transfers.** A transfer on a port occurs on a rising edge where both valid and ready are 1.
- **`load_en`** = !`out_valid` | `out_ready`: the output register is empty or is draining this cycle.
- **Grant, explicit mode:**
  - `grant_ok` = (`sel` < N) & `in_valid[sel]`; `grant` = `sel`.
  - If `sel` >= N, no channel is granted and all `in_ready` = 0.
- **Grant, round-robin mode:**
  - Scan channels `ptr`+1, `ptr`+2, … modulo N, wrapping from N-1 to 0.
  - `grant` is the first channel with `in_valid` = 1.
  - `grant_ok` = any `in_valid`.
- **`in_ready`.** `in_ready[i]` = !`rst` & `load_en` & `grant_ok` & (`grant` == i). At most one bit is ever set. `in_ready` must not depend on `in_valid[i]` of any channel other than through the grant logic above.
- **Rising edge with `load_en` & `grant_ok`:**
  - `out_data` <= word of channel `grant`.
  - `out_ch` <= `grant`.
  - `out_valid` <= 1.
  - `ptr` <= `grant`. `ptr` updates in both modes, so a switch to round-robin continues fairly from the last served channel.
- **Rising edge with `load_en` & !`grant_ok`:** `out_valid` <= 0; `out_data` and `out_ch` hold their old values.
- **Rising edge with !`load_en` (stall):** `out_data`, `out_ch`, `out_valid` and `ptr` all hold. `out_data` must stay stable while `out_valid` & !`out_ready`.
- **Reset values:**
  - `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
  - `ptr` = N-1, so channel 0 has first priority after reset.
  - `in_ready` = 0 throughout reset.
- **Reset asserted mid-transfer.** Any word held in the output register is discarded immediately; no handshake completes while `rst` = 1.
- **`rr_en` or `sel` changed during a stall.** No effect on the held word; the new selection applies to the next load.
- **Upstream behaviour.** Upstream may drop `in_valid` without a transfer. The block does not require upstream data to stay stable.

## Timing
- Latency is 1 cycle from input transfer to `out_valid`/`out_data`.
- Throughput is 1 word per cycle while `out_ready` stays 1. There is no bubble on back-to-back transfers, including a channel change.
- `in_ready` is a combinational path from `out_ready`, `out_valid`, `in_valid`, `sel`, `rr_en`, `ptr` and `rst`.
- `out_*` are registered only; there is no combinational path from inputs to `out_*`.
- Reset assertion clears the registers asynchronously. Release is sampled on the next rising edge; the first transfer is possible on the first edge with `rst` = 0.

## Test plan
All scenarios use WIDTH=8, N=4 unless stated.
- **Reset.** Assert `rst` with all `in_valid` = 1 → `out_valid` = 0, `out_data` = 0x00, `out_ch` = 0, `in_ready` = 0000. After release, the first edge loads channel 0 in round-robin mode.
- **Explicit mode.** `rr_en` = 0, `sel` = 2, `in_data[2]` = 0xA5, all valid, `out_ready` = 1 → `in_ready` = 0100. Next cycle `out_data` = 0xA5, `out_ch` = 2. Set `sel` = 1 with 0x3C → 0x3C follows the next cycle with no bubble.
- **Round-robin fairness.** `rr_en` = 1, all four valid continuously, `out_ready` = 1 → `out_ch` sequence 0,1,2,3,0,1 on consecutive cycles. With only channels 1 and 3 valid → sequence 1,3,1,3.
- **Backpressure.** Word 0x11 loaded, then `out_ready` = 0 for 3 cycles → `out_data` holds 0x11, `out_valid` = 1, `in_ready` = 0000. The cycle `out_ready` returns to 1, a transfer and a new load occur on the same edge.
- **Non-power-of-two N and empty selection.** N=3, `rr_en` = 0, `sel` = 3 → `in_ready` = 000, and `out_valid` falls to 0 after the pending word drains. N=3, `rr_en` = 1 → wrap-around 2→0 is verified.
- **Reset mid-stream.** Assert `rst` while `out_valid` = 1 and `out_ready` = 0 → `out_valid` = 0 immediately, no transfer is counted, and `ptr` restarts so the next grant is channel 0.
